// File: rtl/regfile_sb.sv
// Register file with a pending-bit scoreboard: combinational reads with optional
// write forwarding, issue/writeback tracking of producers, stall and flush.
module regfile_sb #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREG),
  localparam int CW    = AW + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_rd,
  input  logic            flush,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            stall,
  output logic [CW-1:0]   pend_cnt
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [NREG-1:0] pend_q, pend_d;
  logic [CW-1:0]   pend_cnt_q, pend_cnt_d;

  logic wr_hit, byp1, byp2, waw, iss_ok;

  always_comb begin
    wr_hit = wr_en && (wr_addr != '0);
    byp1   = (BYPASS != 0) && wr_hit && (wr_addr == rs1_addr);
    byp2   = (BYPASS != 0) && wr_hit && (wr_addr == rs2_addr);

    // Reset masking keeps forwarded write data off the read ports while rst_n is low.
    rs1_data = '0;
    rs2_data = '0;
    if (rst_n) begin
      rs1_data = byp1 ? wr_data : regs_q[rs1_addr];
      rs2_data = byp2 ? wr_data : regs_q[rs2_addr];
    end

    rs1_busy = rst_n && pend_q[rs1_addr] && !byp1;
    rs2_busy = rst_n && pend_q[rs2_addr] && !byp2;
    waw      = iss_en && pend_q[iss_rd] && !(wr_en && (wr_addr == iss_rd));
    stall    = rst_n && (rs1_busy || rs2_busy || waw);
    iss_ok   = iss_en && !stall && (iss_rd != '0);
  end

  always_comb begin
    regs_d = regs_q;
    if (wr_hit) regs_d[wr_addr] = wr_data;

    // Writeback clears first so a same-cycle issue to that register wins; flush beats both.
    pend_d = pend_q;
    if (wr_en)  pend_d[wr_addr] = 1'b0;
    if (iss_ok) pend_d[iss_rd]  = 1'b1;
    if (flush)  pend_d = '0;
    pend_d[0] = 1'b0;

    pend_cnt_d = '0;
    for (int i = 1; i < NREG; i++) begin
      pend_cnt_d = pend_cnt_d + CW'(pend_d[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q     <= '{default: '0};
      pend_q     <= '0;
      pend_cnt_q <= '0;
    end else begin
      regs_q     <= regs_d;
      pend_q     <= pend_d;
      pend_cnt_q <= pend_cnt_d;
    end
  end

  assign pend_cnt = pend_cnt_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: a vector table for the default configuration plus
// hand sequences for BYPASS=0, NREG=16 and asynchronous reset.
module tb_regfile_sb;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rs1_addr, rs2_addr, wr_addr, iss_rd;
  logic        wr_en, iss_en, flush;
  logic [31:0] wr_data;

  logic [31:0] rs1_data, rs2_data, nb_rs1_data, nb_rs2_data;
  logic        rs1_busy, rs2_busy, stall, nb_rs1_busy, nb_rs2_busy, nb_stall;
  logic [5:0]  pend_cnt, nb_pend_cnt;

  logic [3:0]  r1_16, r2_16, wa16, ird16;
  logic        we16, ie16, fl16;
  logic [31:0] wd16, d1_16, d2_16;
  logic        b1_16, b2_16, st16;
  logic [4:0]  cnt16;

  int checks = 0;
  int failures = 0;

  regfile_sb dut (
    .clk(clk), .rst_n(rst_n), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .iss_en(iss_en), .iss_rd(iss_rd), .flush(flush),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .stall(stall), .pend_cnt(pend_cnt)
  );

  regfile_sb #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(nb_rs1_data), .rs2_data(nb_rs2_data), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .iss_en(iss_en), .iss_rd(iss_rd), .flush(flush),
    .rs1_busy(nb_rs1_busy), .rs2_busy(nb_rs2_busy), .stall(nb_stall), .pend_cnt(nb_pend_cnt)
  );

  regfile_sb #(.NREG(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .rs1_addr(r1_16), .rs2_addr(r2_16),
    .rs1_data(d1_16), .rs2_data(d2_16), .wr_en(we16), .wr_addr(wa16),
    .wr_data(wd16), .iss_en(ie16), .iss_rd(ird16), .flush(fl16),
    .rs1_busy(b1_16), .rs2_busy(b2_16), .stall(st16), .pend_cnt(cnt16)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [4:0]  r1, r2;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        ie;
    logic [4:0]  ird;
    logic        fl;
    logic [31:0] d1, d2;
    logic        b1, b2, st;
    logic [5:0]  cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [4:0] r1, input logic [4:0] r2, input logic we,
                     input logic [4:0] wa, input logic [31:0] wd, input logic ie,
                     input logic [4:0] ird, input logic fl, input logic [31:0] d1,
                     input logic [31:0] d2, input logic b1, input logic b2,
                     input logic st, input logic [5:0] cnt);
    vec_t v;
    v.r1 = r1; v.r2 = r2; v.we = we; v.wa = wa; v.wd = wd; v.ie = ie; v.ird = ird;
    v.fl = fl; v.d1 = d1; v.d2 = d2; v.b1 = b1; v.b2 = b2; v.st = st; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] r1, input logic [4:0] r2, input logic we,
                       input logic [4:0] wa, input logic [31:0] wd, input logic ie,
                       input logic [4:0] ird, input logic fl);
    rs1_addr = r1; rs2_addr = r2; wr_en = we; wr_addr = wa; wr_data = wd;
    iss_en = ie; iss_rd = ird; flush = fl;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    r1_16 = 0; r2_16 = 0; we16 = 0; wa16 = 0; wd16 = 0; ie16 = 0; ird16 = 0; fl16 = 0;

    //  r1  r2  we wa  wd            ie ird fl | d1            d2            b1 b2 st cnt
    add(0,  0,  0, 0,  32'h0,        0, 0,  0,   32'h0,        32'h0,        0, 0, 0, 0);
    add(5,  0,  1, 5,  32'hDEADBEEF, 0, 0,  0,   32'hDEADBEEF, 32'h0,        0, 0, 0, 0);
    add(5,  0,  1, 0,  32'h00001234, 0, 0,  0,   32'hDEADBEEF, 32'h0,        0, 0, 0, 0);
    add(0,  0,  0, 0,  32'h0,        0, 0,  0,   32'h0,        32'h0,        0, 0, 0, 0);
    add(5,  7,  1, 7,  32'hA5A5A5A5, 0, 0,  0,   32'hDEADBEEF, 32'hA5A5A5A5, 0, 0, 0, 0);
    add(0,  0,  0, 0,  32'h0,        1, 3,  0,   32'h0,        32'h0,        0, 0, 0, 0);
    add(3,  0,  0, 0,  32'h0,        0, 0,  0,   32'h0,        32'h0,        1, 0, 1, 1);
    add(3,  0,  1, 3,  32'h00000033, 0, 0,  0,   32'h00000033, 32'h0,        0, 0, 0, 1);
    add(3,  0,  0, 0,  32'h0,        0, 0,  0,   32'h00000033, 32'h0,        0, 0, 0, 0);
    add(0,  0,  1, 9,  32'h00000099, 1, 9,  0,   32'h0,        32'h0,        0, 0, 0, 0);
    add(0,  0,  0, 0,  32'h0,        1, 9,  0,   32'h0,        32'h0,        0, 0, 1, 1);
    add(9,  0,  0, 0,  32'h0,        1, 10, 0,   32'h00000099, 32'h0,        1, 0, 1, 1);
    add(0,  10, 0, 0,  32'h0,        0, 0,  0,   32'h0,        32'h0,        0, 0, 0, 1);
    add(0,  0,  1, 9,  32'h0000009A, 1, 9,  0,   32'h0,        32'h0,        0, 0, 0, 1);
    add(9,  0,  1, 9,  32'h0000009B, 0, 0,  0,   32'h0000009B, 32'h0,        0, 0, 0, 1);
    add(0,  0,  0, 0,  32'h0,        1, 1,  0,   32'h0,        32'h0,        0, 0, 0, 0);
    add(0,  0,  0, 0,  32'h0,        1, 2,  0,   32'h0,        32'h0,        0, 0, 0, 1);
    add(0,  0,  0, 0,  32'h0,        1, 4,  0,   32'h0,        32'h0,        0, 0, 0, 2);
    add(1,  4,  0, 0,  32'h0,        0, 0,  0,   32'h0,        32'h0,        1, 1, 1, 3);
    add(0,  0,  1, 2,  32'h00000022, 1, 6,  1,   32'h0,        32'h0,        0, 0, 0, 3);
    add(6,  2,  0, 0,  32'h0,        0, 0,  0,   32'h0,        32'h00000022, 0, 0, 0, 0);
    add(1,  4,  0, 0,  32'h0,        0, 0,  0,   32'h0,        32'h0,        0, 0, 0, 0);

    #3;
    chk("reset_rs1_data", rs1_data, 0);
    chk("reset_pend_cnt", pend_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].r1, vecs[i].r2, vecs[i].we, vecs[i].wa, vecs[i].wd,
            vecs[i].ie, vecs[i].ird, vecs[i].fl);
      #1;
      chk($sformatf("v%0d_rs1_data", i), rs1_data, vecs[i].d1);
      chk($sformatf("v%0d_rs2_data", i), rs2_data, vecs[i].d2);
      chk($sformatf("v%0d_rs1_busy", i), rs1_busy, vecs[i].b1);
      chk($sformatf("v%0d_rs2_busy", i), rs2_busy, vecs[i].b2);
      chk($sformatf("v%0d_stall", i), stall, vecs[i].st);
      chk($sformatf("v%0d_pend_cnt", i), pend_cnt, vecs[i].cnt);
    end

    // BYPASS=0 reads the pre-write value and keeps busy during writeback
    @(negedge clk);
    drive(0, 7, 1, 7, 32'h11111111, 0, 0, 0);
    #1;
    chk("byp_rs2_data", rs2_data, 32'h11111111);
    chk("nobyp_rs2_data", nb_rs2_data, 32'hA5A5A5A5);
    @(negedge clk);
    drive(0, 7, 0, 0, 0, 1, 8, 0);
    #1;
    chk("nobyp_rs2_after", nb_rs2_data, 32'h11111111);
    @(negedge clk);
    drive(8, 0, 1, 8, 32'h88, 0, 0, 0);
    #1;
    chk("byp_busy_masked", rs1_busy, 0);
    chk("nobyp_busy_kept", nb_rs1_busy, 1);
    chk("nobyp_stall", nb_stall, 1);
    chk("nobyp_rs1_old", nb_rs1_data, 0);

    // Asynchronous reset in the middle of a cycle
    @(negedge clk);
    drive(0, 0, 1, 20, 32'h0000ABCD, 1, 12, 0);
    @(negedge clk);
    drive(12, 20, 1, 20, 32'h00005555, 1, 13, 0);
    #1;
    chk("pre_rst_busy", rs1_busy, 1);
    chk("pre_rst_stall", stall, 1);
    chk("pre_rst_cnt", pend_cnt, 1);
    chk("pre_rst_rs2_byp", rs2_data, 32'h00005555);
    rst_n = 1'b0;
    #1;
    chk("rst_rs1_data", rs1_data, 0);
    chk("rst_rs2_data", rs2_data, 0);
    chk("rst_rs1_busy", rs1_busy, 0);
    chk("rst_stall", stall, 0);
    chk("rst_pend_cnt", pend_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(20, 12, 0, 0, 0, 1, 3, 0);
    #1;
    chk("post_rst_rs1_data", rs1_data, 0);
    chk("post_rst_rs2_busy", rs2_busy, 0);
    chk("post_rst_stall", stall, 0);
    @(negedge clk);
    drive(3, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("post_rst_cnt", pend_cnt, 1);
    chk("post_rst_busy3", rs1_busy, 1);

    // NREG=16: top register, same-cycle issue and write keeps pending set
    @(negedge clk);
    we16 = 1; wa16 = 15; wd16 = 32'h0000F00D; ie16 = 1; ird16 = 15;
    @(negedge clk);
    we16 = 0; ie16 = 0; r1_16 = 15;
    #1;
    chk("n16_rs1_data", d1_16, 32'h0000F00D);
    chk("n16_rs1_busy", b1_16, 1);
    chk("n16_pend_cnt", cnt16, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
